// File: rtl/toy_lsu_mem_initiator.sv
// Load/store unit front end: turns one core load/store request into one or two
// word accesses on a zero-delay memory, handling unaligned accesses that
// straddle a word boundary, and returns a single response to the core.
module toy_lsu_mem_initiator #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [31:0]           rsp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_rd_data,
  output logic [31:0]           mem_wr_data,
  output logic [3:0]            mem_wr_byte_en,
  output logic                  mem_wr_en
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RSP} state_t;

  state_t state_reg, state_next;

  // Registered request
  logic                  wr_reg;
  logic                  signed_reg;
  logic [1:0]            size_reg;
  logic [ADDR_WIDTH+1:0] addr_reg;
  logic [31:0]           wdata_reg;
  // Captured read words (word1 stays 0 for non-crossing loads)
  logic [31:0]           word0_reg;
  logic [31:0]           word1_reg;

  // Derived access geometry
  logic [1:0]            offset;
  logic [2:0]            nbytes;
  logic [3:0]            base_mask;
  logic                  crosses;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [ADDR_WIDTH-1:0] word_idx_inc;
  logic [63:0]           lane;
  logic [7:0]            mask;
  logic [63:0]           rd_pair;
  logic [31:0]           rd_shifted;
  logic [31:0]           load_result;
  logic                  handshake;

  assign offset = addr_reg[1:0];

  // Size 3 is treated exactly like a word access
  always_comb begin
    case (size_reg)
      2'd0:    begin nbytes = 3'd1; base_mask = 4'b0001; end
      2'd1:    begin nbytes = 3'd2; base_mask = 4'b0011; end
      default: begin nbytes = 3'd4; base_mask = 4'b1111; end
    endcase
  end

  // offset+nbytes peaks at 7, so 3 bits suffice without overflow
  assign crosses      = ({1'b0, offset} + nbytes) > 3'd4;
  assign word_idx     = addr_reg[ADDR_WIDTH+1:2];
  // Natural modulo-2^ADDR_WIDTH wrap for an access starting in the top word
  assign word_idx_inc = word_idx + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  // Store data and byte mask spread over a two-word window
  assign lane = {32'd0, wdata_reg} << {offset, 3'b000};
  assign mask = {4'd0, base_mask} << offset;

  // Load data re-aligned from the two-word window, then extended
  assign rd_pair    = {word1_reg, word0_reg};
  assign rd_shifted = rd_pair[{offset, 3'b000} +: 32];

  always_comb begin
    case (nbytes)
      3'd1:    load_result = {{24{signed_reg & rd_shifted[7]}},  rd_shifted[7:0]};
      3'd2:    load_result = {{16{signed_reg & rd_shifted[15]}}, rd_shifted[15:0]};
      default: load_result = rd_shifted;
    endcase
  end

  assign handshake = req_vld & req_rdy;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and all FSM-driven outputs; memory outputs are zero outside ACC states
  always_comb begin
    state_next     = state_reg;
    req_rdy        = 1'b0;
    rsp_vld        = 1'b0;
    rsp_rdata      = 32'd0;
    mem_addr       = '0;
    mem_wr_data    = 32'd0;
    mem_wr_byte_en = 4'd0;
    mem_wr_en      = 1'b0;
    case (state_reg)
      IDLE: begin
        req_rdy = 1'b1;
        if (req_vld) state_next = ACC0;
      end
      ACC0: begin
        mem_addr = word_idx;
        if (wr_reg) begin
          mem_wr_data    = lane[31:0];
          mem_wr_byte_en = mask[3:0];
          mem_wr_en      = |mask[3:0];
        end
        state_next = crosses ? ACC1 : RSP;
      end
      ACC1: begin
        mem_addr = word_idx_inc;
        if (wr_reg) begin
          mem_wr_data    = lane[63:32];
          mem_wr_byte_en = mask[7:4];
          mem_wr_en      = |mask[7:4];
        end
        state_next = RSP;
      end
      RSP: begin
        rsp_vld   = 1'b1;
        rsp_rdata = wr_reg ? 32'd0 : load_result;
        if (rsp_rdy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture and load-word capture at the end of each ACC state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_reg     <= 1'b0;
      signed_reg <= 1'b0;
      size_reg   <= 2'd0;
      addr_reg   <= '0;
      wdata_reg  <= 32'd0;
      word0_reg  <= 32'd0;
      word1_reg  <= 32'd0;
    end else begin
      if (handshake) begin
        wr_reg     <= req_wr;
        signed_reg <= req_signed;
        size_reg   <= req_size;
        addr_reg   <= req_addr;
        wdata_reg  <= req_wdata;
        word0_reg  <= 32'd0;
        word1_reg  <= 32'd0;
      end
      if (state_reg == ACC0 && !wr_reg) word0_reg <= mem_rd_data;
      if (state_reg == ACC1 && !wr_reg) word1_reg <= mem_rd_data;
    end
  end

endmodule
